// File: rtl/contador_bidirecional.sv
// ---------------------------------------------------------------------------
// contador_bidirecional
//
// Parametrised up/down counter used as the sweep/address generator for the
// display, PWM and scan blocks. It counts between MIN and MAX in one of four
// modes: ping-pong (bounce between the bounds), up-wrap, down-wrap or hold.
// It also has a count enable, a terminal flag aligned with the count, and an
// optional synchronous load.
//
// Optional feature macro:
//   CONTADOR_BIDIR_LOAD_EN  when defined, adds the load/load_val ports and the
//                           clamped synchronous load path.
//
// Parameters:
//   WIDTH  counter width in bits
//   MIN    lower bound (0 <= MIN < MAX)
//   MAX    upper bound (MAX <= 2**WIDTH-1)
//
// Ports:
//   clk       in   sole clock, every register updates on its rising edge
//   reset     in   synchronous, active-low reset
//   en        in   count enable; when low the state holds (load still works)
//   mode      in   00 ping-pong, 01 up-wrap, 10 down-wrap, 11 hold
//   load      in   synchronous load strobe        (CONTADOR_BIDIR_LOAD_EN only)
//   load_val  in   value to load, clamped to bounds (CONTADOR_BIDIR_LOAD_EN only)
//   saida     out  current count, registered
//   dir       out  current direction, 0 = up, 1 = down, registered
//   tc        out  terminal flag: next enabled step turns or wraps, registered
// ---------------------------------------------------------------------------
module contador_bidirecional #(
   parameter int WIDTH = 4,
   parameter int MIN   = 0,
   parameter int MAX   = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
`ifdef CONTADOR_BIDIR_LOAD_EN
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`endif
   output logic [WIDTH-1:0] saida,
   output logic             dir,
   output logic             tc
);

   typedef enum logic [1:0] {
      MODE_PINGPONG  = 2'b00,
      MODE_UP_WRAP   = 2'b01,
      MODE_DOWN_WRAP = 2'b10,
      MODE_HOLD      = 2'b11
   } mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   localparam logic [WIDTH-1:0] MIN_W      = WIDTH'(MIN);
   localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] MIN_PLUS_1 = WIDTH'(MIN + 1);
   localparam logic [WIDTH-1:0] MAX_MINUS_1 = WIDTH'(MAX - 1);
   localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);

   mode_t            mode_sel;
   dir_t             dir_q;
   dir_t             dir_next;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] count_inc;
   logic [WIDTH-1:0] count_dec;
   logic             tc_q;
   logic             tc_next;
   logic             at_min;
   logic             at_max;

   assign mode_sel = mode_t'(mode);

   // The bounds are always tested before an increment or decrement is
   // selected, so the raw +1/-1 results below are only ever used when they
   // cannot carry or borrow, even with MIN = 0 and MAX = 2**WIDTH-1.
   assign count_inc = count_q + ONE_W;
   assign count_dec = count_q - ONE_W;
   assign at_min    = (count_q == MIN_W);
   assign at_max    = (count_q == MAX_W);

`ifdef CONTADOR_BIDIR_LOAD_EN
   logic [WIDTH-1:0] load_clamped;
   logic             load_below_min;
   logic             load_above_max;

   // A loaded value is forced into [MIN, MAX] so the counter can never sit
   // outside its bounds. The lower test is written as (x+1 <= MIN) one bit
   // wider so that it stays a real comparison when MIN is zero.
   assign load_below_min = (({1'b0, load_val} + (WIDTH+1)'(1)) <= {1'b0, MIN_W});
   assign load_above_max = (load_val > MAX_W);

   always_comb begin
      load_clamped = load_val;
      if (load_below_min) begin
         load_clamped = MIN_W;
      end else if (load_above_max) begin
         load_clamped = MAX_W;
      end
   end
`endif

   // Next-state logic. Load outranks the enable and the mode, and leaves the
   // direction untouched. With en high the mode decides the step: ping-pong
   // turns around on the bound it reaches, so each endpoint is shown for a
   // single enabled cycle; the wrap modes force their own direction on every
   // enabled edge; hold freezes everything.
   always_comb begin
      count_next = count_q;
      dir_next   = dir_q;
`ifdef CONTADOR_BIDIR_LOAD_EN
      if (load) begin
         count_next = load_clamped;
      end else
`endif
      if (en) begin
         case (mode_sel)
            MODE_PINGPONG: begin
               if (dir_q == DIR_UP) begin
                  if (at_max) begin
                     count_next = MAX_MINUS_1;
                     dir_next   = DIR_DOWN;
                  end else begin
                     count_next = count_inc;
                  end
               end else begin
                  if (at_min) begin
                     count_next = MIN_PLUS_1;
                     dir_next   = DIR_UP;
                  end else begin
                     count_next = count_dec;
                  end
               end
            end
            MODE_UP_WRAP: begin
               dir_next   = DIR_UP;
               count_next = at_max ? MIN_W : count_inc;
            end
            MODE_DOWN_WRAP: begin
               dir_next   = DIR_DOWN;
               count_next = at_min ? MAX_W : count_dec;
            end
            default: begin
               count_next = count_q;
               dir_next   = dir_q;
            end
         endcase
      end
   end

   // The terminal flag is derived from the next count and direction so that
   // it is registered on the same edge as them and always describes the
   // value currently on saida.
   always_comb begin
      tc_next = ((dir_next == DIR_UP)   && (count_next == MAX_W)) ||
                ((dir_next == DIR_DOWN) && (count_next == MIN_W));
   end

   // State register with synchronous active-low reset. Reset parks the
   // counter at MIN heading up with the flag clear, so counting restarts
   // upward on the first enabled edge after reset is released.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= MIN_W;
         dir_q   <= DIR_UP;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_next;
         dir_q   <= dir_next;
         tc_q    <= tc_next;
      end
   end

   assign saida = count_q;
   assign dir   = dir_q;
   assign tc    = tc_q;

endmodule

// File: tb/tb_contador_bidirecional.sv
// ---------------------------------------------------------------------------
// tb_contador_bidirecional
//
// Drives three counters side by side (4-bit 0..15, 8-bit 0..255 and 4-bit
// 3..9) through directed sequences and a randomised stretch, comparing every
// output after every edge against a behavioural model written with plain
// integer arithmetic. The load checks are compiled in only when
// CONTADOR_BIDIR_LOAD_EN is defined.
// ---------------------------------------------------------------------------
module tb_contador_bidirecional;

   logic       clk = 1'b0;
   logic       reset;
   logic       en_s   [3];
   logic [1:0] mode_s [3];

   logic [3:0] s0;
   logic [7:0] s1;
   logic [3:0] s2;
   logic       d0, d1, d2;
   logic       t0, t1, t2;

`ifdef CONTADOR_BIDIR_LOAD_EN
   logic       ld_s [3];
   logic [3:0] lv0;
   logic [7:0] lv1;
   logic [3:0] lv2;
   int         lvModel [3];
`endif

   int nAssert = 0;
   int nFail   = 0;

   int mMin [3] = '{0, 0, 3};
   int mMax [3] = '{15, 255, 9};
   int mv   [3];
   int md   [3];

   always #5 clk = ~clk;

   contador_bidirecional #(.WIDTH(4), .MIN(0), .MAX(15)) dut0 (
      .clk      (clk),
      .reset    (reset),
      .en       (en_s[0]),
      .mode     (mode_s[0]),
`ifdef CONTADOR_BIDIR_LOAD_EN
      .load     (ld_s[0]),
      .load_val (lv0),
`endif
      .saida    (s0),
      .dir      (d0),
      .tc       (t0)
   );

   contador_bidirecional #(.WIDTH(8), .MIN(0), .MAX(255)) dut1 (
      .clk      (clk),
      .reset    (reset),
      .en       (en_s[1]),
      .mode     (mode_s[1]),
`ifdef CONTADOR_BIDIR_LOAD_EN
      .load     (ld_s[1]),
      .load_val (lv1),
`endif
      .saida    (s1),
      .dir      (d1),
      .tc       (t1)
   );

   contador_bidirecional #(.WIDTH(4), .MIN(3), .MAX(9)) dut2 (
      .clk      (clk),
      .reset    (reset),
      .en       (en_s[2]),
      .mode     (mode_s[2]),
`ifdef CONTADOR_BIDIR_LOAD_EN
      .load     (ld_s[2]),
      .load_val (lv2),
`endif
      .saida    (s2),
      .dir      (d2),
      .tc       (t2)
   );

   // Single comparison point: counts, asserts, and reports on failure.
   task automatic compare(input string tag, input int obs, input int exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   // Reads the outputs of counter i as integers.
   task automatic readDut(input int i, output int v, output int d, output int t);
      case (i)
         0: begin v = int'(s0); d = int'(d0); t = int'(t0); end
         1: begin v = int'(s1); d = int'(d1); t = int'(t1); end
         default: begin v = int'(s2); d = int'(d2); t = int'(t2); end
      endcase
   endtask

   // Reference behaviour of counter i for one rising edge, using the input
   // values present at that edge. Wrap modes use modular arithmetic on the
   // offset from MIN.
   task automatic updateModel(input int i);
      int span;
      span = mMax[i] - mMin[i];
      if (reset == 1'b0) begin
         mv[i] = mMin[i];
         md[i] = 0;
      end
`ifdef CONTADOR_BIDIR_LOAD_EN
      else if (ld_s[i] == 1'b1) begin
         if (lvModel[i] < mMin[i])      mv[i] = mMin[i];
         else if (lvModel[i] > mMax[i]) mv[i] = mMax[i];
         else                           mv[i] = lvModel[i];
      end
`endif
      else if (en_s[i] == 1'b1) begin
         case (int'(mode_s[i]))
            0: begin
               if (md[i] == 0) begin
                  if (mv[i] == mMax[i]) begin mv[i] = mMax[i] - 1; md[i] = 1; end
                  else mv[i] = mv[i] + 1;
               end else begin
                  if (mv[i] == mMin[i]) begin mv[i] = mMin[i] + 1; md[i] = 0; end
                  else mv[i] = mv[i] - 1;
               end
            end
            1: begin
               md[i] = 0;
               mv[i] = mMin[i] + ((mv[i] - mMin[i] + 1) % (span + 1));
            end
            2: begin
               md[i] = 1;
               mv[i] = mMin[i] + ((mv[i] - mMin[i] + span) % (span + 1));
            end
            default: ;
         endcase
      end
   endtask

   // Compares counter i against the model; tc is derived from the model state.
   task automatic checkOutput(input int i);
      int v, d, t, mt;
      readDut(i, v, d, t);
      mt = ((md[i] == 0 && mv[i] == mMax[i]) || (md[i] == 1 && mv[i] == mMin[i])) ? 1 : 0;
      compare($sformatf("dut%0d_saida", i), v, mv[i]);
      compare($sformatf("dut%0d_dir", i), d, md[i]);
      compare($sformatf("dut%0d_tc", i), t, mt);
   endtask

   // Directed expectation for counter i, written straight from the sequence.
   task automatic expectVal(input string tag, input int i, input int v, input int d, input int t);
      int ov, od, ot;
      readDut(i, ov, od, ot);
      compare({tag, "_saida"}, ov, v);
      compare({tag, "_dir"}, od, d);
      compare({tag, "_tc"}, ot, t);
   endtask

   // Advances n edges: the model takes the inputs seen at each edge, then all
   // outputs are sampled 1 time unit after it.
   task automatic applyStimulus(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         for (int i = 0; i < 3; i++) updateModel(i);
         #1;
         for (int i = 0; i < 3; i++) checkOutput(i);
      end
   endtask

   initial begin
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         en_s[i]   = 1'b0;
         mode_s[i] = 2'b00;
         mv[i]     = mMin[i];
         md[i]     = 0;
`ifdef CONTADOR_BIDIR_LOAD_EN
         ld_s[i]    = 1'b0;
         lvModel[i] = 0;
`endif
      end
`ifdef CONTADOR_BIDIR_LOAD_EN
      lv0 = 4'd0;
      lv1 = 8'd0;
      lv2 = 4'd0;
`endif
      #2;

      $display("[TB] reset for two edges");
      applyStimulus(2);
      expectVal("reset0", 0, 0, 0, 0);
      expectVal("reset1", 1, 0, 0, 0);
      expectVal("reset2", 2, 3, 0, 0);
      reset = 1'b1;

      $display("[TB] ping-pong 0..15 with enable gating");
      en_s[0] = 1'b1; mode_s[0] = 2'b00;
      applyStimulus(15);
      expectVal("pp_top", 0, 15, 0, 1);
      en_s[0] = 1'b0;
      applyStimulus(1);
      expectVal("gate_hold15", 0, 15, 0, 1);
      en_s[0] = 1'b1;
      applyStimulus(1);
      expectVal("gate_step14", 0, 14, 1, 0);
      en_s[0] = 1'b0;
      applyStimulus(1);
      expectVal("gate_hold14", 0, 14, 1, 0);
      en_s[0] = 1'b1;
      applyStimulus(14);
      expectVal("pp_bottom", 0, 0, 1, 1);
      applyStimulus(1);
      expectVal("pp_turn", 0, 1, 0, 0);
      applyStimulus(30);
      expectVal("pp_period", 0, 1, 0, 0);

      $display("[TB] up-wrap and down-wrap 0..255");
      en_s[1] = 1'b1; mode_s[1] = 2'b01;
      applyStimulus(254);
      expectVal("uw_254", 1, 254, 0, 0);
      applyStimulus(1);
      expectVal("uw_255", 1, 255, 0, 1);
      applyStimulus(1);
      expectVal("uw_0", 1, 0, 0, 0);
      applyStimulus(1);
      expectVal("uw_1", 1, 1, 0, 0);
      mode_s[1] = 2'b10;
      applyStimulus(1);
      expectVal("dw_0", 1, 0, 1, 1);
      applyStimulus(1);
      expectVal("dw_255", 1, 255, 1, 0);
      applyStimulus(1);
      expectVal("dw_254", 1, 254, 1, 0);

      $display("[TB] offset bounds 3..9 with hold");
      en_s[2] = 1'b1; mode_s[2] = 2'b00;
      applyStimulus(6);
      expectVal("off_top", 2, 9, 0, 1);
      applyStimulus(6);
      expectVal("off_bottom", 2, 3, 1, 1);
      applyStimulus(1);
      expectVal("off_turn", 2, 4, 0, 0);
      applyStimulus(2);
      expectVal("off_at6", 2, 6, 0, 0);
      mode_s[2] = 2'b11;
      applyStimulus(5);
      expectVal("off_hold6", 2, 6, 0, 0);
      mode_s[2] = 2'b00;
      applyStimulus(1);
      expectVal("off_resume", 2, 7, 0, 0);

`ifdef CONTADOR_BIDIR_LOAD_EN
      $display("[TB] load with clamping");
      en_s[2] = 1'b0; ld_s[2] = 1'b1;
      lv2 = 4'd12; lvModel[2] = 12;
      applyStimulus(1);
      expectVal("load_hi", 2, 9, 0, 1);
      lv2 = 4'd1; lvModel[2] = 1;
      applyStimulus(1);
      expectVal("load_lo", 2, 3, 0, 0);
      en_s[2] = 1'b1;
      lv2 = 4'd3; lvModel[2] = 3;
      applyStimulus(1);
      expectVal("load_vs_en", 2, 3, 0, 0);
      ld_s[2] = 1'b0;
`endif

      $display("[TB] randomised stretch");
      for (int k = 0; k < 400; k++) begin
         reset = ($urandom_range(0, 49) != 0);
         for (int i = 0; i < 3; i++) begin
            en_s[i]   = ($urandom_range(0, 3) != 0);
            mode_s[i] = 2'($urandom_range(0, 3));
`ifdef CONTADOR_BIDIR_LOAD_EN
            ld_s[i]    = ($urandom_range(0, 7) == 0);
            lvModel[i] = (i == 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
`endif
         end
`ifdef CONTADOR_BIDIR_LOAD_EN
         lv0 = 4'(lvModel[0]);
         lv1 = 8'(lvModel[1]);
         lv2 = 4'(lvModel[2]);
`endif
         applyStimulus(1);
      end

      $display("[TB] reset mid-count");
      for (int i = 0; i < 3; i++) begin
         en_s[i]   = 1'b0;
         mode_s[i] = 2'b00;
`ifdef CONTADOR_BIDIR_LOAD_EN
         ld_s[i] = 1'b0;
`endif
      end
      reset = 1'b0;
      applyStimulus(1);
      reset = 1'b1;
      en_s[0] = 1'b1;
      applyStimulus(19);
      expectVal("pre_reset", 0, 11, 1, 0);
      reset = 1'b0;
      applyStimulus(1);
      expectVal("mid_reset", 0, 0, 0, 0);
      reset = 1'b1;
      applyStimulus(1);
      expectVal("restart_up", 0, 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule

// File: doc/contador_bidirecional.md
# contador_bidirecional

Parametrised up/down counter with selectable counting mode: ping-pong between two bounds, wrap up, wrap down, or hold. It also has a count enable, an aligned terminal flag and an optional synchronous load. It generalises the fixed 4-bit 0..15 bounce counter to arbitrary width and bounds. It is the standard sweep/address generator for the team's display, PWM and scan blocks.

## Interface
- WIDTH, 4, counter width in bits
- MIN, 0, lower bound; must satisfy 0 ≤ MIN < MAX
- MAX, 15, upper bound; must satisfy MAX ≤ 2^WIDTH−1
- clk  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising clk edge
- en  in  1  count enable; when low, state holds (load still honoured)
- mode  in  2  00 ping-pong, 01 up-wrap, 10 down-wrap, 11 hold
- load  in  1  synchronous load strobe (only with CONTADOR_BIDIR_LOAD_EN)
- load_val  in  WIDTH  value for load (only with CONTADOR_BIDIR_LOAD_EN)
- saida  out  WIDTH  current count, registered
- dir  out  1  current direction, 0 = up, 1 = down, registered
- tc  out  1  terminal flag, registered

## Operation
- Priority per edge, highest first: reset low, then load, then en, then hold.
- Reset (reset == 0 at an edge): saida = MIN, dir = 0, tc = 0.
- Load: saida = load_val clamped to [MIN, MAX]; below MIN → MIN, above MAX → MAX. dir is unchanged. Load ignores en and mode.
- en = 1, mode 00 (ping-pong):
  - dir 0, saida < MAX → saida+1.
  - dir 0, saida == MAX → saida = MAX−1, dir = 1.
  - dir 1, saida > MIN → saida−1.
  - dir 1, saida == MIN → saida = MIN+1, dir = 0.
  - Each endpoint appears for exactly one enabled cycle per visit. Period is 2·(MAX−MIN) enabled cycles.
- en = 1, mode 01 (up-wrap): dir = 0. saida == MAX → MIN, else saida+1.
- en = 1, mode 10 (down-wrap): dir = 1. saida == MIN → MAX, else saida−1.
- en = 1, mode 11 (hold): saida and dir unchanged.
- Mode changes take effect at the first enabled edge after the change. A switch into 01 or 10 forces dir on that edge. A switch into 00 resumes from the current saida and dir.
- If MAX−MIN == 1, ping-pong alternates MIN, MAX, MIN, …
- Arithmetic is WIDTH bits. Bounds are compared before any increment or decrement, so no carry or borrow ever occurs, including MAX = 2^WIDTH−1 and MIN = 0.
- tc is high whenever the next enabled step will turn or wrap:
  - (dir == 0 and saida == MAX), or (dir == 1 and saida == MIN).
  - It is registered together with saida/dir, so all three outputs change on the same edge.

## Timing
- One-cycle latency: inputs sampled at edge N are visible on saida/dir/tc after edge N.
- No combinational path from any input to any output.
- When en is low, outputs are stable indefinitely. tc keeps its level.
- Reset mid-count takes effect at the next edge, regardless of en, load or mode. Counting restarts upward from MIN on the first enabled edge after reset returns high.
- Simultaneous load and en: load wins and no count step occurs on that edge.

## Configuration
- CONTADOR_BIDIR_LOAD_EN defined: the load and load_val ports exist and behave as above.
- Undefined: both ports are absent from the port list, with no load logic. All other behaviour is identical.

## Test plan
- Reset and ping-pong (defaults): hold reset low for 2 edges, then en = 1, mode = 00. saida runs 0,1,…,15,14,…,0,1.
  - tc is high exactly at the 15 (dir 0) and the 0 (dir 1) visits.
  - dir toggles on the edges leaving 15 and leaving 0. The period is 30 cycles.
- Up-wrap and down-wrap (WIDTH = 8, MIN = 0, MAX = 255): no overflow in either direction.
  - mode 01: saida goes 254, 255, 0, 1.
  - mode 10: saida goes 1, 0, 255, 254, with dir = 1 throughout.
- Offset bounds (MIN = 3, MAX = 9), ping-pong: sequence 3..9, 8..3, 4. Force mode 11 at saida = 6 for 5 cycles: saida stays 6, then resumes in the same direction.
- Enable gating: toggle en every other cycle in ping-pong at saida = 15, dir 0. saida holds 15 with tc high while en is low, then steps to 14 on the next enabled edge.
- Load (macro defined, MIN = 3, MAX = 9):
  - load_val = 12 → saida = 9.
  - load_val = 1 → saida = 3.
  - load together with en → no count step on that edge.
  - With the macro undefined, the bench elaborates without the load ports.
- Reset mid-operation: assert reset low at saida = 11, dir 1, mode 00. The next edge gives saida = 0, dir = 0, tc = 0, and counting restarts upward.
